// File: rtl/kgp_pkg.sv
// Shared constants for the PC generation stage: FSM state codes, datapath widths
// and the default reset vector.
package kgp_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IMEM_AW = 10;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

endpackage

// File: rtl/pc_gen_unit.sv
// Program-counter generation stage: owns the architectural PC, handles advance,
// redirect, stall and halt. Optional PC_BOUNDS_CHECK_EN adds a registered pc_fault.
module pc_gen_unit
    import kgp_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned     IMEM_DEPTH   = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            halt,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus1,
`ifdef PC_BOUNDS_CHECK_EN
    output logic            pc_fault,
`endif
    output logic            instr_valid,
    output logic            halted
);

    logic [1:0] state;

    assign pc_plus1 = pc + 32'd1;

`ifdef PC_BOUNDS_CHECK_EN
    logic [XLEN-1:0] next_pc;
    logic            next_oor;

    // Candidate is checked even under stall: the check ranks above stall.
    always_comb begin
        next_pc  = branch_taken ? branch_target : pc_plus1;
        next_oor = (next_pc >= XLEN'(IMEM_DEPTH));
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_BOOT;
            pc          <= RESET_VECTOR;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
            pc_fault    <= 1'b0;
`endif
        end else begin
            case (state)
                S_BOOT: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (halt) begin
                        state       <= S_HALT;
                        halted      <= 1'b1;
                        instr_valid <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
                    end else if (next_oor) begin
                        state       <= S_HALT;
                        halted      <= 1'b1;
                        instr_valid <= 1'b0;
                        pc_fault    <= 1'b1;
`endif
                    end else if (branch_taken) begin
                        // Redirect beats stall; the word fetched this cycle is wrong-path.
                        pc          <= branch_target;
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        pc          <= pc_plus1;
                        instr_valid <= 1'b1;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Randomized bench for pc_gen_unit against a behavioural PC model; directed
// scenarios first, then random stall/branch/halt/reset traffic.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        instr_valid;
    logic        halted;
`ifdef PC_BOUNDS_CHECK_EN
    logic        pc_fault;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_halted;
    logic        m_booting;
    logic        m_fault;

    pc_gen_unit #(.RESET_VECTOR(32'h0000_0000), .IMEM_DEPTH(1024)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .halt(halt),
        .pc(pc),
        .pc_plus1(pc_plus1),
`ifdef PC_BOUNDS_CHECK_EN
        .pc_fault(pc_fault),
`endif
        .instr_valid(instr_valid),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic apply(input logic r, input logic st, input logic br,
                         input logic [31:0] tgt, input logic hl);
        logic [31:0] cand;
        logic        oob;
        rst = r; stall = st; branch_taken = br; branch_target = tgt; halt = hl;
        @(posedge clk);
        if (!r) begin
            m_pc = 32'h0; m_valid = 0; m_halted = 0; m_booting = 1; m_fault = 0;
        end else if (m_booting) begin
            m_booting = 0;
        end else if (!m_halted) begin
            cand = br ? tgt : m_pc + 32'd1;
            oob  = 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
            oob  = (cand >= 32'd1024);
`endif
            if (hl) begin
                m_halted = 1; m_valid = 0;
            end else if (oob) begin
                m_halted = 1; m_valid = 0; m_fault = 1;
            end else if (br) begin
                m_pc = tgt; m_valid = 0;
            end else if (!st) begin
                m_pc = m_pc + 32'd1; m_valid = 1;
            end
        end
        #1;
        check_eq("pc", pc, m_pc);
        check_eq("pc_plus1", pc_plus1, m_pc + 32'd1);
        check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check_eq("halted", {31'b0, halted}, {31'b0, m_halted});
`ifdef PC_BOUNDS_CHECK_EN
        check_eq("pc_fault", {31'b0, pc_fault}, {31'b0, m_fault});
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply(1, 0, 0, '0, 0);
    endtask

    initial begin
        m_pc = '0; m_valid = 0; m_halted = 0; m_booting = 1; m_fault = 0;

        // Reset then free-run: pc 0(boot),0,1,2,3 ; valid 0,0,1,1,1
        apply(0, 0, 0, '0, 0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_valid", {31'b0, instr_valid}, 32'h0);
        apply(1, 0, 0, '0, 0);
        check_eq("boot_pc", pc, 32'h0);
        check_eq("boot_valid", {31'b0, instr_valid}, 32'h0);
        run(3);
        check_eq("run_pc3", pc, 32'h3);
        check_eq("run_valid", {31'b0, instr_valid}, 32'h1);
        run(2);

        // Redirect at pc=5: one bubble, then target+1 valid
        check_eq("pre_branch_pc", pc, 32'h5);
        apply(1, 0, 1, 32'h40, 0);
        check_eq("branch_pc", pc, 32'h40);
        check_eq("branch_bubble", {31'b0, instr_valid}, 32'h0);
        run(1);
        check_eq("branch_next_pc", pc, 32'h41);
        check_eq("branch_valid", {31'b0, instr_valid}, 32'h1);

        // Stall at pc=7, then stall with redirect
        apply(1, 0, 1, 32'h6, 0);
        run(1);
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 0, '0, 0);
            check_eq("stall_pc", pc, 32'h7);
            check_eq("stall_valid", {31'b0, instr_valid}, 32'h1);
        end
        run(1);
        check_eq("unstall_pc", pc, 32'h8);
        apply(1, 1, 1, 32'h10, 0);
        check_eq("stall_branch_pc", pc, 32'h10);

        // Halt together with branch at pc=9
        apply(1, 0, 1, 32'h8, 0);
        run(1);
        apply(1, 0, 1, 32'h80, 1);
        check_eq("halt_pc", pc, 32'h9);
        check_eq("halt_flag", {31'b0, halted}, 32'h1);
        apply(1, 1, 0, '0, 0);
        apply(1, 0, 1, 32'h20, 0);
        run(2);
        check_eq("halt_frozen_pc", pc, 32'h9);
        apply(0, 0, 0, '0, 0);
        check_eq("unhalt_pc", pc, 32'h0);
        check_eq("unhalt_flag", {31'b0, halted}, 32'h0);
        run(4);

        // Reset during a redirect discards the redirect
        apply(0, 0, 1, 32'h55, 0);
        check_eq("rst_redirect_pc", pc, 32'h0);
        apply(1, 0, 1, 32'h55, 0);
        check_eq("rst_redirect_boot", pc, 32'h0);
        run(2);

`ifdef PC_BOUNDS_CHECK_EN
        apply(1, 0, 1, 32'd1020, 0);
        run(3);
        check_eq("edge_pc", pc, 32'd1023);
        run(1);
        check_eq("oob_pc", pc, 32'd1023);
        check_eq("oob_fault", {31'b0, pc_fault}, 32'h1);
        check_eq("oob_halted", {31'b0, halted}, 32'h1);
        apply(0, 0, 0, '0, 0);
        run(2);
        apply(1, 0, 1, 32'h400, 0);
        check_eq("oob_branch_fault", {31'b0, pc_fault}, 32'h1);
        check_eq("oob_branch_halted", {31'b0, halted}, 32'h1);
        apply(0, 0, 0, '0, 0);
        run(1);
`else
        // 32-bit wrap without any flag
        apply(1, 0, 1, 32'hFFFF_FFFF, 0);
        check_eq("wrap_plus1", pc_plus1, 32'h0);
        run(1);
        check_eq("wrap_pc", pc, 32'h0);
        check_eq("wrap_halted", {31'b0, halted}, 32'h0);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, st, br, hl;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) >= 3);
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 5) == 0);
            hl  = ($urandom_range(0, 59) == 0);
`ifdef PC_BOUNDS_CHECK_EN
            tgt = 32'($urandom_range(0, 1100));
`else
            tgt = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1100));
`endif
            apply(r, st, br, tgt, hl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
